// File: rtl/ez_usb_fx2lp_slave_model.sv
// Purpose: FX2LP slave-FIFO responder with an OUT FIFO (host to FPGA) and an IN FIFO (FPGA to host).
// Latency: OUT words show on fd_out the cycle after the host push; IN words reach m_axis the cycle after commit.
// Backpressure: s_axis_tready drops when the OUT FIFO is full; flagb reports a full IN FIFO; m_axis waits on tready.
// Ports: clk/rst and ez_usb_reset_n (both synchronous, flushing); ez_usb_* is the slave-FIFO bus
// seen by the FPGA master; s_axis feeds the OUT FIFO; m_axis drains committed IN packets;
// overflow/underflow are sticky error flags.
module ez_usb_fx2lp_slave_model #(
  parameter int DEPTH_LOG2 = 10,
  parameter int PKT_WORDS  = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ez_usb_reset_n,
  input  logic [1:0]  ez_usb_addr,
  input  logic        ez_usb_slcs_n,
  input  logic        ez_usb_sloe_n,
  input  logic        ez_usb_slrd_n,
  input  logic        ez_usb_slwr_n,
  input  logic        ez_usb_pktend_n,
  input  logic [15:0] ez_usb_fd_in,
  output logic [15:0] ez_usb_fd_out,
  output logic        ez_usb_fd_oe,
  output logic        ez_usb_flaga,
  output logic        ez_usb_flagb,
  output logic        ez_usb_flagc,
  input  logic [15:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic        overflow,
  output logic        underflow
);

  localparam int                  LP_DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LP_ONE      = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0] LP_PKT_LAST = (DEPTH_LOG2+1)'(PKT_WORDS - 1);

  logic w_rst;
  logic w_sel_out;
  logic w_sel_in;
  assign w_rst     = rst | ~ez_usb_reset_n;
  assign w_sel_out = ~ez_usb_slcs_n && (ez_usb_addr == 2'b00);
  assign w_sel_in  = ~ez_usb_slcs_n && (ez_usb_addr == 2'b10);

  // ---------------- OUT FIFO (host -> FPGA), first-word-fall-through ----------------
  logic [15:0]         r_out_mem [LP_DEPTH];
  logic [DEPTH_LOG2:0] r_out_wp;
  logic [DEPTH_LOG2:0] r_out_rp;
  logic                w_out_empty;
  logic                w_out_full;
  logic                w_rd_req;
  logic                w_out_pop;
  logic                w_out_push;
  logic [15:0]         w_out_head;

  assign w_out_empty = (r_out_wp == r_out_rp);
  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign w_out_full  = (r_out_wp[DEPTH_LOG2] != r_out_rp[DEPTH_LOG2]) &&
                       (r_out_wp[DEPTH_LOG2-1:0] == r_out_rp[DEPTH_LOG2-1:0]);
  assign w_out_head  = r_out_mem[r_out_rp[DEPTH_LOG2-1:0]];
  assign w_rd_req    = w_sel_out && ~ez_usb_slrd_n;
  assign w_out_pop   = w_rd_req && ~w_out_empty;

  assign s_axis_tready = ~w_rst && ~w_out_full;
  assign w_out_push    = s_axis_tvalid && s_axis_tready;

  assign ez_usb_fd_oe  = ~w_rst && w_sel_out && ~ez_usb_sloe_n;
  assign ez_usb_fd_out = (ez_usb_fd_oe && ~w_out_empty) ? w_out_head : 16'h0000;

  always_ff @(posedge clk) begin
    if (w_out_push) r_out_mem[r_out_wp[DEPTH_LOG2-1:0]] <= s_axis_tdata;
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_out_wp <= '0;
      r_out_rp <= '0;
    end else begin
      if (w_out_push) r_out_wp <= r_out_wp + LP_ONE;
      if (w_out_pop)  r_out_rp <= r_out_rp + LP_ONE;
    end
  end

  // ---------------- IN FIFO (FPGA -> host), packet-committed ----------------
  // Entry = {end, data}. Words between r_in_cp and r_in_wp are written but not yet
  // committed; only [r_in_rp, r_in_cp) is visible on m_axis.
  logic [16:0]         r_in_mem [LP_DEPTH];
  logic [DEPTH_LOG2:0] r_in_wp;
  logic [DEPTH_LOG2:0] r_in_cp;
  logic [DEPTH_LOG2:0] r_in_rp;
  logic [DEPTH_LOG2:0] w_in_run;
  logic [DEPTH_LOG2:0] w_in_prev;
  logic                w_in_full;
  logic                w_wr_req;
  logic                w_in_wr;
  logic                w_pktend;
  logic                w_wr_end;
  logic                w_late_end;
  logic                w_in_valid;
  logic                w_in_pop;
  logic [16:0]         w_in_head;

  assign w_in_full  = (r_in_wp[DEPTH_LOG2] != r_in_rp[DEPTH_LOG2]) &&
                      (r_in_wp[DEPTH_LOG2-1:0] == r_in_rp[DEPTH_LOG2-1:0]);
  assign w_in_run   = r_in_wp - r_in_cp;
  assign w_in_prev  = r_in_wp - LP_ONE;
  assign w_wr_req   = w_sel_in && ~ez_usb_slwr_n;
  assign w_in_wr    = w_wr_req && ~w_in_full;
  assign w_pktend   = w_sel_in && ~ez_usb_pktend_n;
  // The word being written closes the packet on pktend or when it completes a full packet.
  assign w_wr_end   = w_pktend || (w_in_run == LP_PKT_LAST);
  // Pktend with no stored write retro-marks the newest pending word; nothing pending means no ZLP.
  assign w_late_end = ~w_in_wr && w_pktend && (w_in_run != '0);

  assign w_in_valid = ~w_rst && (r_in_cp != r_in_rp);
  assign w_in_pop   = w_in_valid && m_axis_tready;
  assign w_in_head  = r_in_mem[r_in_rp[DEPTH_LOG2-1:0]];

  assign m_axis_tvalid = w_in_valid;
  assign m_axis_tdata  = w_in_valid ? w_in_head[15:0] : 16'h0000;
  assign m_axis_tlast  = w_in_valid && w_in_head[16];

  always_ff @(posedge clk) begin
    if (w_in_wr)
      r_in_mem[r_in_wp[DEPTH_LOG2-1:0]] <= {w_wr_end, ez_usb_fd_in};
    else if (w_late_end)
      r_in_mem[w_in_prev[DEPTH_LOG2-1:0]][16] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_in_wp <= '0;
      r_in_cp <= '0;
      r_in_rp <= '0;
    end else begin
      if (w_in_wr) begin
        r_in_wp <= r_in_wp + LP_ONE;
        if (w_wr_end) r_in_cp <= r_in_wp + LP_ONE;
      end else if (w_late_end) begin
        r_in_cp <= r_in_wp;
      end
      if (w_in_pop) r_in_rp <= r_in_rp + LP_ONE;
    end
  end

  // ---------------- sticky errors and flags ----------------
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_req && w_in_full)   r_overflow  <= 1'b1;
      if (w_rd_req && w_out_empty) r_underflow <= 1'b1;
    end
  end

  assign overflow     = r_overflow;
  assign underflow    = r_underflow;
  assign ez_usb_flaga = 1'b1;
  assign ez_usb_flagb = w_in_full;
  assign ez_usb_flagc = w_out_empty;

endmodule

// File: doc/ez_usb_fx2lp_slave_model.md
# ez_usb_fx2lp_slave_model

Synthesizable responder for the FX2LP slave-FIFO bus: it emulates the USB chip's side of the interface (endpoint FIFOs, FLAGB/FLAGC, SLRD/SLWR/SLOE/PKTEND sampling). It is driven by the FPGA-side slave-FIFO master. The other end is exposed to a host-side stream: host→FPGA data (OUT endpoint, addr 00) and FPGA→host packets (IN endpoint, addr 10). It serves as a loopback/bring-up target on boards without the USB chip, and as the bus model in system benches.

## Interface
Parameters:
- DEPTH_LOG2, 10, log2 of each endpoint FIFO depth in 16-bit words (both FIFOs).
- PKT_WORDS, 256, IN packet size in words (512 bytes); a full packet auto-commits.

Ports:
- clk  in  1  the IFCLK domain; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ez_usb_reset_n  in  1  active-low chip reset from master; sampled synchronously, flushes like rst.
- ez_usb_addr  in  2  FIFO select: 00 = OUT FIFO (read by FPGA), 10 = IN FIFO (written by FPGA); 01/11 = no endpoint.
- ez_usb_slcs_n  in  1  chip select, active low; all strobes ignored when high.
- ez_usb_sloe_n  in  1  output enable, active low.
- ez_usb_slrd_n  in  1  read strobe, active low.
- ez_usb_slwr_n  in  1  write strobe, active low.
- ez_usb_pktend_n  in  1  packet end, active low.
- ez_usb_fd_in  in  16  data bus from FPGA.
- ez_usb_fd_out  out  16  data bus to FPGA.
- ez_usb_fd_oe  out  1  high = model drives the bus.
- ez_usb_flaga  out  1  constant 1 (unused).
- ez_usb_flagb  out  1  1 = IN FIFO full.
- ez_usb_flagc  out  1  1 = OUT FIFO empty.
- s_axis_tdata / tvalid / tready  in/in/out  16/1/1  host→FPGA words into OUT FIFO.
- m_axis_tdata / tvalid / tlast / tready  out/out/out/in  16/1/1/1  committed IN packets to host; tlast on the last word of each packet.
- overflow  out  1  sticky: write to full IN FIFO.
- underflow  out  1  sticky: read from empty OUT FIFO.

## Operation
- Reset (rst or ez_usb_reset_n = 0): both FIFOs emptied, uncommitted IN words discarded, sticky flags cleared. Outputs: fd_out = 0, fd_oe = 0, flaga = 1, flagb = 0, flagc = 1, s_axis_tready = 0, m_axis_tvalid = 0, m_axis_tlast = 0, overflow = 0, underflow = 0.
- Strobe qualification: sel_out = !slcs_n && addr == 00; sel_in = !slcs_n && addr == 10.
- OUT FIFO, first-word-fall-through: fd_out = head word whenever sel_out && !sloe_n && non-empty, else 0. fd_oe = sel_out && !sloe_n (combinational).
- Pop on an edge with sel_out && !slrd_n && non-empty. On empty: no pop, underflow set.
- Host push on s_axis_tvalid && s_axis_tready. s_axis_tready = !rst && OUT not full. Push and pop in the same cycle are both honoured; the count is unchanged.
- IN write on an edge with sel_in && !slwr_n: fd_in is stored with an end bit. If the IN FIFO is full, the word is dropped and overflow is set.
- Commit rules: the stored word is marked end and the committed pointer advances past it when either:
  - pktend_n = 0 on the same edge, or
  - the uncommitted run reaches PKT_WORDS.
- pktend_n = 0 without slwr marks the most recent uncommitted word as end and commits; with no uncommitted words it is ignored (no ZLP).
- m_axis presents only committed words; tlast = stored end bit. Pop on tvalid && tready.
- flagb = IN occupancy (committed + uncommitted) == 2^DEPTH_LOG2. flagc = OUT occupancy == 0.
- Flags decode registered counters only, so each reflects the state after the most recent edge.
- Strobes with addr 01/11 or slcs_n = 1: no effect.

## Timing
- OUT: host push at edge N → flagc = 0 after edge N; fd_out shows the word combinationally once sloe/addr are valid; the pop edge removes it, and the next word or 0 appears after that edge.
- IN: write at edge N with pktend → m_axis_tvalid = 1 after edge N (one-cycle commit latency). Without commit, tvalid stays 0.
- Full-to-not-full: flagb falls after the edge of the first m_axis pop.
- FPGA write and host pop in the same cycle at full: pop happens and the write still overflows (occupancy is checked before the edge).
- Pointer width DEPTH_LOG2+1; wrap-around is handled by MSB comparison.

## Test plan
- Host pushes 0x1111, 0x2222, 0x3333; master runs three addr-00 reads → fd_out sampled 0x1111, 0x2222, 0x3333 in order; flagc = 1 after the third pop; underflow = 0.
- Master writes 0xA000..0xA004 with pktend_n low on the fifth → m_axis_tvalid stays 0 until that edge, then emits 5 words, tlast only on 0xA004.
- Master writes 256 words with no pktend → one packet on m_axis, tlast on word 256; a 257th word plus pktend → separate 1-word packet with tlast.
- m_axis_tready = 0, master writes 1024 words → flagb = 1 after the 1024th edge; a 1025th write is dropped, overflow = 1; one host pop → flagb = 0.
- slrd_n pulse at addr 00 with OUT empty → underflow = 1, fd_out = 0, flagc stays 1.
- ez_usb_reset_n low for 1 cycle with 3 words queued each way plus 2 uncommitted → all outputs return to reset values; no stale words appear afterwards.
